sync_fifo_rd: RTL and testbench

SYNC_FIFO_RD -- requirements
Module: sync_fifo_rd

---
 rtl/sync_fifo_rd_if.sv | 21 ++
 rtl/sync_fifo_rd.sv | 135 +++++++++++++
 tb/tb_sync_fifo_rd.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_rd_if.sv
// sync_fifo_rd_if: output word stream of the FIFO read side.
// Signals: odata/ovalid (producer -> consumer), iready (consumer -> producer).
interface sync_fifo_rd_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic              iready;

    modport master (
        output odata,
        output ovalid,
        input  iready
    );

    modport slave (
        input  odata,
        input  ovalid,
        output iready
    );
endinterface

// File: rtl/sync_fifo_rd.sv
// sync_fifo_rd: read side of a synchronous RAM FIFO with a 2-word skid buffer.
// Optional macro SYNC_FIFO_RD_FLUSH_EN adds the iflush port.
// Ports:
//   iclk, irst   clock, synchronous active-high reset
//   iflush       (SYNC_FIFO_RD_FLUSH_EN only) drop all pending words
//   iwr_ptr      writer pointer, MSB is the wrap bit
//   r_addr       RAM read address (registered read, 1-cycle latency)
//   ram_rdata    RAM read data
//   s_out        odata/ovalid/iready stream
//   ord_ptr      pop pointer back to the writer
//   olevel       iwr_ptr - ord_ptr
//   oempty       olevel == 0
//   oerr         sticky overflow (olevel above 2**ADDR_W)
module sync_fifo_rd #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
) (
    input  logic              iclk,
    input  logic              irst,
`ifdef SYNC_FIFO_RD_FLUSH_EN
    input  logic              iflush,
`endif
    input  logic [ADDR_W:0]   iwr_ptr,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    sync_fifo_rd_if.master    s_out,
    output logic [ADDR_W:0]   ord_ptr,
    output logic [ADDR_W:0]   olevel,
    output logic              oempty,
    output logic              oerr
);

    logic [ADDR_W:0]   r_iss_ptr;
    logic [ADDR_W:0]   r_ord_ptr;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [1:0]        r_cnt;
    logic              r_err;

    logic              w_pop;
    logic              w_fill;
    logic              w_issue;
    logic              w_over;
    logic [2:0]        w_occ;
    logic [DATA_W-1:0] w_buf0_nxt;
    logic [DATA_W-1:0] w_buf1_nxt;
    logic [1:0]        w_cnt_nxt;

    assign r_addr  = r_iss_ptr[ADDR_W-1:0];
    assign ord_ptr = r_ord_ptr;
    assign olevel  = iwr_ptr - r_ord_ptr;
    assign oempty  = (olevel == '0);
    assign oerr    = r_err;

    assign s_out.odata  = r_buf0;
    assign s_out.ovalid = (r_cnt != 2'd0);

    assign w_pop  = s_out.ovalid & s_out.iready;
    assign w_fill = r_inflight;

    // Buffer slots that will be committed after this edge, counting the
    // word still in flight from the RAM; a new read needs one free slot.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_iss_ptr != iwr_ptr) && (w_occ < 3'd2);

    // Level beyond one full RAM can only come from a misbehaving writer.
    assign w_over = olevel[ADDR_W] && (|olevel[ADDR_W-1:0]);

    always_comb begin
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        w_cnt_nxt  = r_cnt;
        unique case ({w_pop, w_fill})
            2'b10: begin
                w_buf0_nxt = r_buf1;
                w_cnt_nxt  = r_cnt - 2'd1;
            end
            2'b01: begin
                if (r_cnt == 2'd0) begin
                    w_buf0_nxt = ram_rdata;
                end else begin
                    w_buf1_nxt = ram_rdata;
                end
                w_cnt_nxt = r_cnt + 2'd1;
            end
            2'b11: begin
                if (r_cnt == 2'd1) begin
                    w_buf0_nxt = ram_rdata;
                end else begin
                    w_buf0_nxt = r_buf1;
                    w_buf1_nxt = ram_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_iss_ptr  <= '0;
            r_ord_ptr  <= '0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_cnt      <= 2'd0;
            r_err      <= 1'b0;
        end
`ifdef SYNC_FIFO_RD_FLUSH_EN
        else if (iflush) begin
            // Clearing inflight drops the word the RAM returns next cycle.
            r_iss_ptr  <= iwr_ptr;
            r_ord_ptr  <= iwr_ptr;
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_err      <= r_err | w_over;
        end
`endif
        else begin
            if (w_issue) begin
                r_iss_ptr <= r_iss_ptr + 1'b1;
            end
            if (w_pop) begin
                r_ord_ptr <= r_ord_ptr + 1'b1;
            end
            r_inflight <= w_issue;
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= r_err | w_over;
        end
    end

endmodule

// File: tb/tb_sync_fifo_rd.sv
// tb_sync_fifo_rd: directed bench for sync_fifo_rd (ADDR_W=4, DATA_W=24)
// with a behavioural writer and one-cycle-read RAM.
module tb_sync_fifo_rd;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
`ifdef SYNC_FIFO_RD_FLUSH_EN
    logic          iflush = 1'b0;
`endif
    logic [AW:0]   wr_ptr = '0;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW:0]   ord_ptr;
    logic [AW:0]   olevel;
    logic          oempty;
    logic          oerr;
    logic [DW-1:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_rd_if #(.DATA_W(DW)) strm ();

    sync_fifo_rd #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iclk      (iclk),
        .irst      (irst),
`ifdef SYNC_FIFO_RD_FLUSH_EN
        .iflush    (iflush),
`endif
        .iwr_ptr   (wr_ptr),
        .r_addr    (r_addr),
        .ram_rdata (ram_rdata),
        .s_out     (strm.master),
        .ord_ptr   (ord_ptr),
        .olevel    (olevel),
        .oempty    (oempty),
        .oerr      (oerr)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) ram_rdata <= mem[r_addr];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr[AW-1:0]] = d;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic do_reset;
        @(negedge iclk);
        irst = 1'b1;
        wr_ptr = '0;
        strm.iready = 1'b0;
        @(negedge iclk);
        @(negedge iclk);
        irst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if (strm.ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovalid got %0b want 0", strm.ovalid);
        end
        n_vec++;
        if (strm.odata !== 24'h0) begin
            n_err++;
            $display("FAIL reset_odata got %h want 000000", strm.odata);
        end
        n_vec++;
        if (ord_ptr !== 5'd0) begin
            n_err++;
            $display("FAIL reset_ord_ptr got %0d want 0", ord_ptr);
        end
        n_vec++;
        if (olevel !== 5'd0 || oempty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_level got %0d/%0b want 0/1", olevel, oempty);
        end
        n_vec++;
        if (oerr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_oerr got %0b want 0", oerr);
        end
    endtask

    task automatic test_stream5;
        strm.iready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge iclk);
            if (c == 1) begin
                n_vec++;
                if (strm.ovalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL s5_latency got ovalid %0b want 0", strm.ovalid);
                end
            end
            if (c >= 2 && c <= 6) begin
                n_vec++;
                if (strm.ovalid !== 1'b1 || strm.odata !== DW'(c - 1)) begin
                    n_err++;
                    $display("FAIL s5_word%0d got %0b/%h want 1/%h",
                             c - 1, strm.ovalid, strm.odata, DW'(c - 1));
                end
            end
            if (c == 7) begin
                n_vec++;
                if (strm.ovalid !== 1'b0 || oempty !== 1'b1) begin
                    n_err++;
                    $display("FAIL s5_end got ovalid %0b oempty %0b want 0 1",
                             strm.ovalid, oempty);
                end
            end
            if (c < 5) push(DW'(c + 1));
        end
    endtask

    task automatic test_fill;
        strm.iready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge iclk);
            push(24'h000100 + DW'(i));
        end
        repeat (4) @(negedge iclk);
        n_vec++;
        if (olevel !== 5'd16) begin
            n_err++;
            $display("FAIL fill_level got %0d want 16", olevel);
        end
        n_vec++;
        if (dut.r_cnt !== 2'd2) begin
            n_err++;
            $display("FAIL fill_count got %0d want 2", dut.r_cnt);
        end
        n_vec++;
        if (strm.ovalid !== 1'b1 || strm.odata !== 24'h000100) begin
            n_err++;
            $display("FAIL fill_head got %0b/%h want 1/000100",
                     strm.ovalid, strm.odata);
        end
        n_vec++;
        if (oerr !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full_err got %0b want 0", oerr);
        end
        strm.iready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (strm.ovalid !== 1'b1 || strm.odata !== 24'h000100 + DW'(i)) begin
                n_err++;
                $display("FAIL fill_drain%0d got %0b/%h want 1/%h",
                         i, strm.ovalid, strm.odata, 24'h000100 + DW'(i));
            end
            @(negedge iclk);
        end
        n_vec++;
        if (strm.ovalid !== 1'b0 || oempty !== 1'b1) begin
            n_err++;
            $display("FAIL fill_end got ovalid %0b oempty %0b want 0 1",
                     strm.ovalid, oempty);
        end
    endtask

    task automatic test_wrap;
        int rx = 0;
        int tx = 0;
        int cyc = 0;
        logic hold = 1'b0;
        logic [DW-1:0] hold_d = '0;
        logic [4:0] pat = 5'b01101;
        while (rx < 40 && cyc < 400) begin
            @(negedge iclk);
            if (hold) begin
                n_vec++;
                if (strm.ovalid !== 1'b1 || strm.odata !== hold_d) begin
                    n_err++;
                    $display("FAIL wrap_hold got %0b/%h want 1/%h",
                             strm.ovalid, strm.odata, hold_d);
                end
            end
            strm.iready = pat[cyc % 5];
            hold = strm.ovalid && !strm.iready;
            hold_d = strm.odata;
            if (strm.ovalid && strm.iready) begin
                n_vec++;
                if (strm.odata !== 24'h000200 + DW'(rx)) begin
                    n_err++;
                    $display("FAIL wrap_word%0d got %h want %h",
                             rx, strm.odata, 24'h000200 + DW'(rx));
                end
                rx++;
            end
            if (tx < 40 && (tx - rx) < 12) begin
                push(24'h000200 + DW'(tx));
                tx++;
            end
            cyc++;
        end
        n_vec++;
        if (rx != 40) begin
            n_err++;
            $display("FAIL wrap_timeout got %0d words want 40", rx);
        end
        strm.iready = 1'b1;
        repeat (3) @(negedge iclk);
        n_vec++;
        if (strm.ovalid !== 1'b0 || oempty !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_extra got ovalid %0b oempty %0b want 0 1",
                     strm.ovalid, oempty);
        end
        n_vec++;
        if (ord_ptr !== 5'd29) begin
            n_err++;
            $display("FAIL wrap_ord_ptr got %0d want 29", ord_ptr);
        end
    endtask

    task automatic test_err;
        @(negedge iclk);
        strm.iready = 1'b0;
        wr_ptr = wr_ptr + 5'd17;
        #1;
        n_vec++;
        if (olevel !== 5'd17) begin
            n_err++;
            $display("FAIL err_level got %0d want 17", olevel);
        end
        @(negedge iclk);
        n_vec++;
        if (oerr !== 1'b1) begin
            n_err++;
            $display("FAIL err_set got %0b want 1", oerr);
        end
        repeat (10) @(negedge iclk);
        n_vec++;
        if (oerr !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky got %0b want 1", oerr);
        end
        do_reset();
        n_vec++;
        if (oerr !== 1'b0 || strm.ovalid !== 1'b0 || ord_ptr !== 5'd0) begin
            n_err++;
            $display("FAIL err_reset got oerr %0b ovalid %0b ord %0d want 0 0 0",
                     oerr, strm.ovalid, ord_ptr);
        end
    endtask

`ifdef SYNC_FIFO_RD_FLUSH_EN
    task automatic test_flush;
        strm.iready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iclk);
            push(24'h000300 + DW'(i));
        end
        @(negedge iclk);
        iflush = 1'b1;
        @(negedge iclk);
        iflush = 1'b0;
        n_vec++;
        if (strm.ovalid !== 1'b0 || olevel !== 5'd0) begin
            n_err++;
            $display("FAIL flush_clear got ovalid %0b level %0d want 0 0",
                     strm.ovalid, olevel);
        end
        push(24'hABCDEF);
        repeat (3) @(negedge iclk);
        strm.iready = 1'b1;
        n_vec++;
        if (strm.ovalid !== 1'b1 || strm.odata !== 24'hABCDEF) begin
            n_err++;
            $display("FAIL flush_next got %0b/%h want 1/abcdef",
                     strm.ovalid, strm.odata);
        end
        @(negedge iclk);
        n_vec++;
        if (strm.ovalid !== 1'b0 || oempty !== 1'b1) begin
            n_err++;
            $display("FAIL flush_end got ovalid %0b oempty %0b want 0 1",
                     strm.ovalid, oempty);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        strm.iready = 1'b0;
        test_reset();
        test_stream5();
        test_fill();
        test_wrap();
        test_err();
`ifdef SYNC_FIFO_RD_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
